frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Parametrised top-level game-loop controller for the falling-squares display. It sequences one logic update per frame, then NUM_LAYERS draw passes, each with a request/done handshake. It then runs an internal frame-delay counter, which replaces the external delay enable. Adds pause/resume, game-over with restart, and a frame counter. Sits between the user inputs (start/pause keys) and the datapath/VGA plotting engines.

Parameters:
NUM_LAYERS, 2, number of draw passes per frame (squares, catcher, ...); >=1
FRAME_TICKS, 833333, clock cycles spent in the delay phase per frame; >=2
FRAME_W, 16, width of the frame counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  level start key; press-and-release begins or restarts a game
pause  in  1  level pause key; each rising edge toggles pause (honoured only in WAIT/PAUSED)
finish_game  in  1  datapath game-over flag, sampled in UPDATE
draw_done  in  NUM_LAYERS  per-layer done pulse/level from the plotting engine
update  out  1  one-cycle pulse: datapath advances one frame
plot  out  1  high while any layer is drawing
draw_sel  out  NUM_LAYERS  one-hot layer being drawn; zero otherwise
layer_idx  out  $clog2(NUM_LAYERS) or 1  binary index of the current layer
frame_count  out  FRAME_W  frames completed since game start; wraps
paused  out  1  high in PAUSED
game_over  out  1  high in OVER

Behaviour:
- States: IDLE, ARM, UPDATE, DRAW, WAIT, PAUSED, OVER.
- Reset, asynchronous or at any time: state IDLE, layer 0, delay counter 0, frame_count 0, pause edge register 0. All outputs 0.
- IDLE: start=1 -> ARM.
- ARM: wait for release. start=0 -> UPDATE. Clear frame_count on entry.
- UPDATE, exactly 1 cycle: update=1.
  - finish_game=1 -> OVER.
  - Otherwise -> DRAW with layer 0.
- DRAW: plot=1, draw_sel=1<<layer, layer_idx=layer.
  - draw_done[layer]=1 with layer<NUM_LAYERS-1 -> layer+1, stay in DRAW.
  - draw_done[layer]=1 with the last layer -> WAIT, delay counter loaded with FRAME_TICKS-1.
  - draw_done bits for other layers are ignored.
  - Minimum one cycle per layer.
- WAIT: delay counter decrements each cycle.
  - Counter==0 -> UPDATE and frame_count+1, modulo 2^FRAME_W. One frame therefore takes FRAME_TICKS WAIT cycles plus the DRAW cycles plus 1 UPDATE cycle.
  - Pause rising edge (pause & ~pause_q) -> PAUSED, counter held.
  - Simultaneous pause edge and counter==0: pause wins, counter stays 0, and resume goes directly to UPDATE on the next WAIT cycle.
- PAUSED: paused=1, all other outputs 0, counter frozen. Pause rising edge -> WAIT.
- Pause edges in any other state are discarded; pause_q is still updated every cycle.
- OVER: game_over=1. start=1 -> ARM (restart). frame_count holds its final value until ARM.
- Outputs are combinational from state/layer only (Moore). No output depends on the inputs in the same cycle.
- The delay counter is $clog2(FRAME_TICKS) bits wide, compares against 0, and never underflows.

Decomposition:
- Shared package: state enum encoding and the LAYER_W / CNT_W width-derivation constants.
- One natural sub-module: frame_delay_counter. Interface: load, enable (hold when paused), zero flag. Parameter: FRAME_TICKS.

Test Plan:
(All with NUM_LAYERS=2, FRAME_TICKS=4.)
1. Start sequence: reset low 3 cycles, then start high 2 cycles then low -> IDLE, ARM, UPDATE. update is a single-cycle pulse. Next cycle shows draw_sel=01, plot=1.
2. Draw handshake: draw_done=01 after 5 cycles, then draw_done=10 after 3 cycles -> draw_sel goes 01->10->00. Exactly 4 WAIT cycles follow, then update pulses and frame_count=1. A stray draw_done=10 during layer 0 is ignored.
3. Pause: pause rises in the 2nd WAIT cycle -> paused=1 and no update for 50 cycles. Second pause rise -> exactly 2 more WAIT cycles, then update. Holding pause high gives no repeat toggle.
4. Pause at counter zero: pause edge coincident with the last WAIT cycle -> PAUSED. On resume -> UPDATE after 1 WAIT cycle. frame_count increments once only.
5. Game over and restart: finish_game=1 during UPDATE -> game_over=1, no draw. Start press/release -> ARM, frame_count=0, update pulse.
6. Async reset mid-DRAW: reset asserted between clock edges -> all outputs 0 immediately. After release, the block stays IDLE until start.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared state encoding and width helpers for the frame sequencer and its delay counter.
package frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_UPDATE = 3'd2,
        ST_DRAW   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_PAUSED = 3'd5,
        ST_OVER   = 3'd6
    } state_e;

    // A single-layer build still needs a 1-bit index bus.
    function automatic int layer_w_f(input int num_layers);
        return (num_layers > 1) ? $clog2(num_layers) : 1;
    endfunction

    function automatic int cnt_w_f(input int frame_ticks);
        return (frame_ticks > 1) ? $clog2(frame_ticks) : 1;
    endfunction

    localparam int DEF_NUM_LAYERS  = 2;
    localparam int DEF_FRAME_TICKS = 833333;
    localparam int DEF_FRAME_W     = 16;
    localparam int LAYER_W         = layer_w_f(DEF_NUM_LAYERS);
    localparam int CNT_W           = cnt_w_f(DEF_FRAME_TICKS);

endpackage

// File: rtl/frame_sequencer_if.sv
// Key inputs, datapath/plotter handshake and status outputs of the frame sequencer.
interface frame_sequencer_if
    import frame_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int FRAME_W    = DEF_FRAME_W
);
    localparam int LW = layer_w_f(NUM_LAYERS);

    logic                  start;
    logic                  pause;
    logic                  finish_game;
    logic [NUM_LAYERS-1:0] draw_done;

    logic                  update;
    logic                  plot;
    logic [NUM_LAYERS-1:0] draw_sel;
    logic [LW-1:0]         layer_idx;
    logic [FRAME_W-1:0]    frame_count;
    logic                  paused;
    logic                  game_over;

    modport master (
        input  start, pause, finish_game, draw_done,
        output update, plot, draw_sel, layer_idx, frame_count, paused, game_over
    );

    modport slave (
        output start, pause, finish_game, draw_done,
        input  update, plot, draw_sel, layer_idx, frame_count, paused, game_over
    );

endinterface

// File: rtl/frame_sequencer_delay_counter.sv
// Per-frame delay down-counter: load to FRAME_TICKS-1, count while enabled, saturate at 0.
// zero_o is registered-state only; no backpressure, the sequencer decides when to advance.
module frame_delay_counter
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic enable_i,
    output logic zero_o
);
    localparam int              CW       = cnt_w_f(FRAME_TICKS);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Game-loop controller: UPDATE pulse, NUM_LAYERS draw passes gated by draw_done, then a timed WAIT.
// Moore outputs (no input-to-output path); pause/game-over stall the loop, nothing else pushes back.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int FRAME_W     = DEF_FRAME_W
) (
    input  logic              clock,
    input  logic              reset,
    frame_sequencer_if.master bus
);
    localparam int               LW         = layer_w_f(NUM_LAYERS);
    localparam logic [LW-1:0]    LAST_LAYER = LW'(NUM_LAYERS - 1);

    state_e              state_q, state_d;
    logic [LW-1:0]       layer_q, layer_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                pause_q;

    logic                pause_edge;
    logic                layer_done;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_zero;

    logic                update_c;
    logic                plot_c;
    logic [NUM_LAYERS-1:0] draw_sel_c;
    logic [LW-1:0]       layer_idx_c;
    logic                paused_c;
    logic                game_over_c;

    assign pause_edge = bus.pause & ~pause_q;
    assign layer_done = bus.draw_done[layer_q];

    frame_delay_counter #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_delay (
        .clock    (clock),
        .reset    (reset),
        .load_i   (cnt_load),
        .enable_i (cnt_en),
        .zero_o   (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        frame_d  = frame_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                    frame_d = '0;
                end
            end
            ST_ARM: begin
                if (!bus.start) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                layer_d = '0;
                state_d = bus.finish_game ? ST_OVER : ST_DRAW;
            end
            ST_DRAW: begin
                if (layer_done) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d  = ST_WAIT;
                        layer_d  = '0;
                        cnt_load = 1'b1;
                    end else begin
                        layer_d = layer_q + LW'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Every WAIT cycle consumes a tick, including the one that pauses;
                // a pause taken at zero therefore resumes straight into UPDATE.
                cnt_en = 1'b1;
                if (pause_edge) begin
                    state_d = ST_PAUSED;
                end else if (cnt_zero) begin
                    state_d = ST_UPDATE;
                    frame_d = frame_q + FRAME_W'(1);
                end
            end
            ST_PAUSED: begin
                if (pause_edge) begin
                    state_d = ST_WAIT;
                end
            end
            ST_OVER: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                    frame_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                layer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            frame_q <= '0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            frame_q <= frame_d;
            pause_q <= bus.pause;
        end
    end

    always_comb begin
        update_c    = 1'b0;
        plot_c      = 1'b0;
        draw_sel_c  = '0;
        layer_idx_c = '0;
        paused_c    = 1'b0;
        game_over_c = 1'b0;
        case (state_q)
            ST_UPDATE: update_c = 1'b1;
            ST_DRAW: begin
                plot_c      = 1'b1;
                draw_sel_c  = NUM_LAYERS'(1) << layer_q;
                layer_idx_c = layer_q;
            end
            ST_PAUSED: paused_c    = 1'b1;
            ST_OVER:   game_over_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.update      = update_c;
    assign bus.plot        = plot_c;
    assign bus.draw_sel    = draw_sel_c;
    assign bus.layer_idx   = layer_idx_c;
    assign bus.frame_count = frame_q;
    assign bus.paused      = paused_c;
    assign bus.game_over   = game_over_c;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with NUM_LAYERS=2, FRAME_TICKS=4.
module tb_frame_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_sequencer_if #(.NUM_LAYERS(2), .FRAME_W(16)) bus();

    frame_sequencer #(
        .NUM_LAYERS  (2),
        .FRAME_TICKS (4),
        .FRAME_W     (16)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] outs();
        return {bus.update, bus.plot, bus.draw_sel, bus.layer_idx,
                bus.frame_count, bus.paused, bus.game_over};
    endfunction

    // From an observed UPDATE cycle, run both draw passes and stop in the first WAIT cycle.
    task automatic goto_wait();
        tick();
        bus.draw_done = 2'b01;
        tick();
        bus.draw_done = 2'b10;
        tick();
        bus.draw_done = 2'b00;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.pause = 1'b0; bus.finish_game = 1'b0; bus.draw_done = 2'b00;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (outs() !== 23'd0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs()); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (outs() !== 23'd0) begin n_bad++; $display("FAIL idle_outs: got %h want 0", outs()); end
    endtask

    task automatic test_start();
        bus.start = 1'b1;
        tick();
        n_cmp++; if (outs() !== 23'd0) begin n_bad++; $display("FAIL arm_quiet: got %h want 0", outs()); end
        tick();
        bus.start = 1'b0;
        tick();
        n_cmp++; if (bus.update !== 1'b1) begin n_bad++; $display("FAIL start_update: got %b want 1", bus.update); end
        n_cmp++; if (bus.plot !== 1'b0) begin n_bad++; $display("FAIL update_noplot: got %b want 0", bus.plot); end
        tick();
        n_cmp++; if (bus.update !== 1'b0) begin n_bad++; $display("FAIL update_pulse_len: got %b want 0", bus.update); end
        n_cmp++; if (bus.draw_sel !== 2'b01) begin n_bad++; $display("FAIL first_draw_sel: got %b want 01", bus.draw_sel); end
        n_cmp++; if (bus.plot !== 1'b1) begin n_bad++; $display("FAIL first_plot: got %b want 1", bus.plot); end
    endtask

    task automatic test_draw_handshake();
        int n;
        bus.draw_done = 2'b10;
        tick();
        n_cmp++; if (bus.draw_sel !== 2'b01) begin n_bad++; $display("FAIL stray_done: got %b want 01", bus.draw_sel); end
        bus.draw_done = 2'b00;
        repeat (3) tick();
        bus.draw_done = 2'b01;
        tick();
        n_cmp++; if (bus.draw_sel !== 2'b10) begin n_bad++; $display("FAIL layer1_sel: got %b want 10", bus.draw_sel); end
        n_cmp++; if (bus.layer_idx !== 1'b1) begin n_bad++; $display("FAIL layer1_idx: got %b want 1", bus.layer_idx); end
        bus.draw_done = 2'b00;
        tick();
        tick();
        bus.draw_done = 2'b10;
        tick();
        bus.draw_done = 2'b00;
        n_cmp++; if ({bus.plot, bus.draw_sel} !== 3'b000) begin n_bad++; $display("FAIL wait_noplot: got %b want 000", {bus.plot, bus.draw_sel}); end
        n = 1;
        tick();
        while (bus.update !== 1'b1 && n < 20) begin n++; tick(); end
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL wait_cycles: got %0d want 4", n); end
        n_cmp++; if (bus.frame_count !== 16'd1) begin n_bad++; $display("FAIL frame_count_1: got %0d want 1", bus.frame_count); end
    endtask

    task automatic test_pause();
        int n;
        int upd_seen;
        int unpaused;
        int paused_seen;
        goto_wait();
        tick();
        bus.pause = 1'b1;
        tick();
        n_cmp++; if (bus.paused !== 1'b1) begin n_bad++; $display("FAIL pause_enter: got %b want 1", bus.paused); end
        n_cmp++; if ({bus.update, bus.plot, bus.draw_sel, bus.game_over} !== 5'b0) begin n_bad++; $display("FAIL paused_quiet: got %b want 0", {bus.update, bus.plot, bus.draw_sel, bus.game_over}); end
        upd_seen = 0; unpaused = 0;
        repeat (50) begin
            tick();
            if (bus.update === 1'b1) upd_seen++;
            if (bus.paused !== 1'b1) unpaused++;
        end
        n_cmp++; if (upd_seen !== 0) begin n_bad++; $display("FAIL paused_no_update: got %0d updates want 0", upd_seen); end
        n_cmp++; if (unpaused !== 0) begin n_bad++; $display("FAIL pause_held_no_toggle: got %0d unpaused cycles want 0", unpaused); end
        bus.pause = 1'b0;
        tick();
        n_cmp++; if (bus.paused !== 1'b1) begin n_bad++; $display("FAIL pause_release_stays: got %b want 1", bus.paused); end
        bus.pause = 1'b1;
        tick();
        n_cmp++; if (bus.paused !== 1'b0) begin n_bad++; $display("FAIL resume: got %b want 0", bus.paused); end
        n = 1; paused_seen = 0;
        tick();
        while (bus.update !== 1'b1 && n < 20) begin
            n++;
            if (bus.paused === 1'b1) paused_seen++;
            tick();
        end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL resume_wait_cycles: got %0d want 2", n); end
        n_cmp++; if (paused_seen !== 0) begin n_bad++; $display("FAIL resume_no_retoggle: got %0d want 0", paused_seen); end
        n_cmp++; if (bus.frame_count !== 16'd2) begin n_bad++; $display("FAIL frame_count_2: got %0d want 2", bus.frame_count); end
        bus.pause = 1'b0;
    endtask

    task automatic test_pause_at_zero();
        goto_wait();
        repeat (3) tick();
        bus.pause = 1'b1;
        tick();
        n_cmp++; if ({bus.paused, bus.update} !== 2'b10) begin n_bad++; $display("FAIL zero_pause_enter: got %b want 10", {bus.paused, bus.update}); end
        n_cmp++; if (bus.frame_count !== 16'd2) begin n_bad++; $display("FAIL zero_pause_fc: got %0d want 2", bus.frame_count); end
        bus.pause = 1'b0;
        tick();
        bus.pause = 1'b1;
        tick();
        n_cmp++; if ({bus.paused, bus.update} !== 2'b00) begin n_bad++; $display("FAIL zero_resume_wait: got %b want 00", {bus.paused, bus.update}); end
        tick();
        n_cmp++; if (bus.update !== 1'b1) begin n_bad++; $display("FAIL zero_resume_update: got %b want 1", bus.update); end
        n_cmp++; if (bus.frame_count !== 16'd3) begin n_bad++; $display("FAIL zero_fc_once: got %0d want 3", bus.frame_count); end
        bus.pause = 1'b0;
        tick();
        n_cmp++; if (bus.frame_count !== 16'd3) begin n_bad++; $display("FAIL zero_fc_hold: got %0d want 3", bus.frame_count); end
    endtask

    task automatic test_game_over();
        bus.draw_done = 2'b01;
        tick();
        bus.draw_done = 2'b10;
        tick();
        bus.draw_done = 2'b00;
        repeat (3) tick();
        bus.finish_game = 1'b1;
        tick();
        n_cmp++; if (bus.update !== 1'b1) begin n_bad++; $display("FAIL over_update: got %b want 1", bus.update); end
        n_cmp++; if (bus.frame_count !== 16'd4) begin n_bad++; $display("FAIL over_fc: got %0d want 4", bus.frame_count); end
        tick();
        bus.finish_game = 1'b0;
        n_cmp++; if ({bus.game_over, bus.plot} !== 2'b10) begin n_bad++; $display("FAIL over_enter: got %b want 10", {bus.game_over, bus.plot}); end
        tick();
        n_cmp++; if ({bus.game_over, bus.plot, bus.update} !== 3'b100) begin n_bad++; $display("FAIL over_hold: got %b want 100", {bus.game_over, bus.plot, bus.update}); end
        n_cmp++; if (bus.frame_count !== 16'd4) begin n_bad++; $display("FAIL over_fc_hold: got %0d want 4", bus.frame_count); end
        bus.start = 1'b1;
        tick();
        n_cmp++; if (bus.frame_count !== 16'd0) begin n_bad++; $display("FAIL restart_fc: got %0d want 0", bus.frame_count); end
        n_cmp++; if (bus.game_over !== 1'b0) begin n_bad++; $display("FAIL restart_over: got %b want 0", bus.game_over); end
        bus.start = 1'b0;
        tick();
        n_cmp++; if (bus.update !== 1'b1) begin n_bad++; $display("FAIL restart_update: got %b want 1", bus.update); end
        tick();
        n_cmp++; if (bus.draw_sel !== 2'b01) begin n_bad++; $display("FAIL restart_draw: got %b want 01", bus.draw_sel); end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (outs() !== 23'd0) begin n_bad++; $display("FAIL async_reset: got %h want 0", outs()); end
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (outs() !== 23'd0) begin n_bad++; $display("FAIL post_reset_idle: got %h want 0", outs()); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        n_cmp++; if (bus.update !== 1'b1) begin n_bad++; $display("FAIL post_reset_start: got %b want 1", bus.update); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_draw_handshake();
        test_pause();
        test_pause_at_zero();
        test_game_over();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
